// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks EX/MEM/WB destinations and drives stall, WB bypass and EX forward selects.
// Optional feature macro: SB_FWD_EN (full forwarding/bypass); undefined = stall until the producer retires.
module id_hazard_scoreboard #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_vld,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_is_rs1,
  input  logic             i_id_is_rs2,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_rd_wren,
  input  logic             i_id_mem_rden,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_id_byp_a,
  output logic             o_id_byp_b,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [4:0] rd;
    logic       ld;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{vld: 1'b0, wr: 1'b0, rd: 5'd0, ld: 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  function automatic logic src_match(input logic       vld,
                                     input logic       is_rs,
                                     input logic [4:0] rs,
                                     input logic       slot_live,
                                     input logic [4:0] slot_rd);
    return vld && is_rs && (rs != 5'd0) && slot_live && (slot_rd == rs);
  endfunction

  slot_t            e_slot_r;
  slot_t            m_slot_r;
  slot_t            w_slot_r;
  slot_t            entry_s;
  logic             a_e_s, a_m_s, a_w_s;
  logic             b_e_s, b_m_s, b_w_s;
  logic             stall_s;
  logic             bubble_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             w_ld_unused_s;

  assign a_e_s = src_match(i_id_vld, i_id_is_rs1, i_id_rs1, e_slot_r.vld && e_slot_r.wr, e_slot_r.rd);
  assign a_m_s = src_match(i_id_vld, i_id_is_rs1, i_id_rs1, m_slot_r.vld && m_slot_r.wr, m_slot_r.rd);
  assign a_w_s = src_match(i_id_vld, i_id_is_rs1, i_id_rs1, w_slot_r.vld && w_slot_r.wr, w_slot_r.rd);
  assign b_e_s = src_match(i_id_vld, i_id_is_rs2, i_id_rs2, e_slot_r.vld && e_slot_r.wr, e_slot_r.rd);
  assign b_m_s = src_match(i_id_vld, i_id_is_rs2, i_id_rs2, m_slot_r.vld && m_slot_r.wr, m_slot_r.rd);
  assign b_w_s = src_match(i_id_vld, i_id_is_rs2, i_id_rs2, w_slot_r.vld && w_slot_r.wr, w_slot_r.rd);

  // The load flag has no consumer once the producer reaches WB.
  assign w_ld_unused_s = w_slot_r.ld;

`ifdef SB_FWD_EN
  assign stall_s    = !i_flush && (a_e_s || b_e_s) && e_slot_r.ld;
  assign o_id_byp_a = a_w_s && !a_e_s && !a_m_s;
  assign o_id_byp_b = b_w_s && !b_e_s && !b_m_s;
`else
  assign stall_s    = !i_flush && (a_e_s || a_m_s || a_w_s || b_e_s || b_m_s || b_w_s);
  assign o_id_byp_a = 1'b0;
  assign o_id_byp_b = 1'b0;
`endif

  assign o_stall  = stall_s;
  assign bubble_s = stall_s || i_flush || !i_id_vld;

  // Build the slot that enters EX on the next edge
  always_comb begin
    entry_s = SLOT_EMPTY;
    if (bubble_s) begin
      entry_s = SLOT_EMPTY;
    end else begin
      entry_s.vld = 1'b1;
      entry_s.wr  = i_id_rd_wren && (i_id_rd != 5'd0);
      entry_s.rd  = i_id_rd;
      entry_s.ld  = i_id_mem_rden;
    end
  end

  // Advance the E/M/W slot pipeline every cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      e_slot_r <= SLOT_EMPTY;
      m_slot_r <= SLOT_EMPTY;
      w_slot_r <= SLOT_EMPTY;
    end else begin
      w_slot_r <= m_slot_r;
      m_slot_r <= e_slot_r;
      e_slot_r <= entry_s;
    end
  end

`ifdef SB_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic e_hit, input logic m_hit);
    logic [1:0] sel;
    if (e_hit) begin
      sel = 2'b01;
    end else if (m_hit) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  logic [1:0] fwd_a_nxt_s;
  logic [1:0] fwd_b_nxt_s;
  logic [1:0] fwd_a_r;
  logic [1:0] fwd_b_r;

  // Resolve the EX operand sources for the instruction about to enter EX
  always_comb begin
    fwd_a_nxt_s = 2'b00;
    fwd_b_nxt_s = 2'b00;
    if (bubble_s) begin
      fwd_a_nxt_s = 2'b00;
      fwd_b_nxt_s = 2'b00;
    end else begin
      fwd_a_nxt_s = fwd_sel(a_e_s, a_m_s);
      fwd_b_nxt_s = fwd_sel(b_e_s, b_m_s);
    end
  end

  // Register the selects alongside the ID/EX pipeline register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else begin
      fwd_a_r <= fwd_a_nxt_s;
      fwd_b_r <= fwd_b_nxt_s;
    end
  end

  assign o_fwd_a_sel = fwd_a_r;
  assign o_fwd_b_sel = fwd_b_r;
`else
  assign o_fwd_a_sel = 2'b00;
  assign o_fwd_b_sel = 2'b00;
`endif

  // Saturating count of stall cycles for performance monitoring
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_stall_cnt = stall_cnt_r;

endmodule

// File: doc/id_hazard_scoreboard.md
# id_hazard_scoreboard

Tracks the destination registers of the instructions in EX, MEM and WB, and compares them against the source registers of the instruction being decoded in ID. Sits beside the ID control unit and consumes its per-instruction decode flags (`rd_wren`, `mem_rden`, `id_is_rs1`, `id_is_rs2`, `o_insn_vld`). It drives:
- the IF/ID stall,
- the ID-stage write-back bypass,
- the registered EX forwarding selects.

It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall counter.

Ports (clock and reset first):
- `i_clk` input 1: clock, rising edge.
- `i_rst_n` input 1: reset, asynchronous assert, active-low.
- `i_id_vld` input 1: ID holds a legal instruction (from `o_insn_vld`).
- `i_id_rs1` input 5: ID source register 1 (`instr[19:15]`).
- `i_id_rs2` input 5: ID source register 2 (`instr[24:20]`).
- `i_id_is_rs1` input 1: ID instruction reads rs1.
- `i_id_is_rs2` input 1: ID instruction reads rs2.
- `i_id_rd` input 5: ID destination register (`instr[11:7]`).
- `i_id_rd_wren` input 1: ID instruction writes rd.
- `i_id_mem_rden` input 1: ID instruction is a load.
- `i_flush` input 1: taken branch or jump resolved in EX; kills the ID instruction.
- `o_stall` output 1: hold PC and IF/ID; insert a bubble into EX.
- `o_id_byp_a` output 1: rs1 read in ID must take WB write data.
- `o_id_byp_b` output 1: rs2 read in ID must take WB write data.
- `o_fwd_a_sel` output 2: EX operand A source. Encoding: 00 = regfile, 01 = MEM-stage ALU result, 10 = WB data, 11 = reserved.
- `o_fwd_b_sel` output 2: EX operand B source, same encoding as `o_fwd_a_sel`.
- `o_stall_cnt` output `CNT_W`: number of stall cycles, saturating.

## Operation
- **Slots.** There are three slots: E, M and W. Each slot holds `{vld, wr, rd[4:0], ld}`.
- **Slot update.** Every cycle: W ← M, M ← E, E ← entry. The pipeline has no downstream back-pressure.
- **Entry.** `entry = {1, i_id_rd_wren && i_id_rd!=0, i_id_rd, i_id_mem_rden}`. When `o_stall`, `i_flush` or `!i_id_vld` is true, entry is a bubble (all zero).
- **Match.** A source `rsX` matches slot S when all of these hold:
  - `i_id_vld`,
  - `i_id_is_rsX`,
  - `rsX != 0`,
  - `S.vld && S.wr`,
  - `S.rd == rsX`.
- **Priority.** E > M > W; the youngest producer wins.
- **Load-use stall.** `o_stall = !i_flush && (match(rs1,E) || match(rs2,E)) && E.ld`.
- **Forward select.** Computed combinationally per source and registered into `o_fwd_*_sel` when the instruction enters EX:
  - E match (non-load) → 01.
  - Otherwise M match → 10.
  - Otherwise → 00.
  - A bubble entry registers 00.
- **ID bypass.** `o_id_byp_X = match(rsX,W)` with no E or M match. It is combinational because the regfile has no internal write-through.
- **Stall counter.** `o_stall_cnt` increments on every cycle with `o_stall`=1 and saturates at all-ones.
- **Flush.** `i_flush` overrides stall. IF/ID is refilled by the fetch stage.
- **Reset.** All slots invalid. `o_fwd_a_sel`, `o_fwd_b_sel` and `o_stall_cnt` = 0. Combinational outputs are therefore 0.

## Timing
- `o_stall`, `o_id_byp_a` and `o_id_byp_b` are combinational from the ID inputs and slot state, valid in the same cycle.
- `o_fwd_a_sel` and `o_fwd_b_sel` update on the rising edge, together with the ID/EX register. They are valid for the whole EX cycle of that instruction.
- **Load-use.** Exactly one stall cycle. The next cycle the load sits in M with a bubble in E; the consumer advances with sel = 10.
- **Reset mid-operation.** Asynchronous. All slots and registered outputs clear immediately. The first post-reset instruction sees no hazards.
- **Simultaneous stall and flush.** Flush wins. `o_stall`=0, a bubble enters E and the counter does not increment.
- **rd = x0.** Never recorded as a writer. A load to x0 causes no stall.
- **Both sources match.** rs1 and rs2 resolve independently. The stall is the OR of both.

## Configuration
- `SB_FWD_EN` defined: full forwarding and bypass as above.
- `SB_FWD_EN` undefined:
  - `o_fwd_a_sel` and `o_fwd_b_sel` are tied to 00; `o_id_byp_a` and `o_id_byp_b` are tied to 0.
  - `o_stall` asserts on any E, M or W match, load or not, and holds until no slot matches (at most 3 cycles).
  - The stall counter is unchanged.

## Test plan
- `addi x5,x0,1` then `add x6,x5,x5` back-to-back → no stall; consumer in EX has `o_fwd_a_sel`=`o_fwd_b_sel`=01.
- `lw x7,0(x1)` then `add x8,x7,x2` → `o_stall`=1 for exactly 1 cycle, then `o_fwd_a_sel`=10, `o_fwd_b_sel`=00; `o_stall_cnt`=1.
- A producer of x9, two independent instructions, then a reader of x9 → `o_id_byp_a`=1 during the reader's ID cycle; fwd sels 00.
- `lw x0,0(x1)` then `add x3,x0,x0` → no stall, no forwarding.
- A load followed by a dependent instruction, with `i_flush`=1 in the stall cycle → `o_stall`=0, bubble into E, counter unchanged.
- Assert `i_rst_n`=0 mid-stream with all slots valid → slots, sels and counter read 0 immediately. Build with `SB_FWD_EN` undefined: `add` followed by a dependent `add` → 3 stall cycles, `o_stall_cnt`=3.
